vga_timing_gen: RTL and testbench

- Downstream consumer of the 108 MHz pixel-clock PLL output and its locked flag.
- Generates 1280x1024@60 VGA raster timing: hsync, vsync, data-enable, pixel coordinates and frame/line strobes for the pixel source and DAC stage.
- Holds the raster idle until the PLL reports lock; restarts cleanly from the top-left pixel after any loss of lock or reset.

---
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the 108 MHz pixel clock.
// The raster stays parked at the top-left pixel until the PLL lock flag has
// passed through a two-flop synchroniser. It restarts from (0,0) after any
// reset or loss of lock. All outputs come from one register stage, so the
// coordinates, enables and syncs for a given pixel appear in the same cycle.
module vga_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 48,
   parameter int H_SYNC   = 112,
   parameter int H_BP     = 248,
   parameter int V_ACTIVE = 1024,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 38,
   parameter int H_POL    = 1,
   parameter int V_POL    = 1,
   parameter int COORD_W  = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
   localparam logic               HS_ACTIVE  = (H_POL != 0);
   localparam logic               VS_ACTIVE  = (V_POL != 0);

   logic               lock_meta_q, lock_meta_d;
   logic               lock_s_q, lock_s_d;
   logic [COORD_W-1:0] h_q, h_d;
   logic [COORD_W-1:0] v_q, v_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               de_q, de_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   logic               count_en;
   logic               de_i, hs_i, vs_i, ls_i, fs_i;

   // Lock synchroniser path: pll_locked is asynchronous to clk
   always_comb begin
      lock_meta_d = pll_locked;
      lock_s_d    = lock_meta_q;
   end

   // Synchroniser flops, cleared by reset so relock always takes two cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
      end
   end

   assign count_en = lock_s_q & ~rst;

   // Pixel/line counters; anything other than enabled counting parks them at (0,0)
   always_comb begin
      h_d = '0;
      v_d = '0;
      if (count_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + COORD_ONE;
         end else begin
            h_d = h_q + COORD_ONE;
            v_d = v_q;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Active-high decode of the current counter position
   always_comb begin
      de_i = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      hs_i = (h_q >= HS_START) && (h_q < HS_END);
      vs_i = (v_q >= VS_START) && (v_q < VS_END);
      ls_i = (h_q == '0);
      fs_i = (h_q == '0) && (v_q == '0);
   end

   // Output register inputs; sync polarity is applied only here
   always_comb begin
      hsync_d       = ~HS_ACTIVE;
      vsync_d       = ~VS_ACTIVE;
      de_d          = 1'b0;
      x_d           = '0;
      y_d           = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (count_en) begin
         hsync_d       = hs_i ? HS_ACTIVE : ~HS_ACTIVE;
         vsync_d       = vs_i ? VS_ACTIVE : ~VS_ACTIVE;
         de_d          = de_i;
         x_d           = h_q;
         y_d           = v_q;
         line_start_d  = ls_i;
         frame_start_d = fs_i;
      end
   end

   // Output register, one cycle behind the counters
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= ~HS_ACTIVE;
         vsync_q       <= ~VS_ACTIVE;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: full 1280x1024 raster, a mid-size positive
// polarity raster for whole-frame timing, and a tiny negative polarity raster.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // full-size instance
   logic rst_a, lk_a, hs_a, vs_a, de_a, ls_a, fs_a;
   logic [10:0] x_a, y_a;
   // mid-size instance: H 16/2/4/3 (25), V 10/1/3/2 (16), frame 400
   logic rst_b, lk_b, hs_b, vs_b, de_b, ls_b, fs_b;
   logic [10:0] x_b, y_b;
   // tiny negative-polarity instance: H 4/1/2/1 (8), V 3/1/1/1 (6), frame 48
   logic rst_c, lk_c, hs_c, vs_c, de_c, ls_c, fs_c;
   logic [10:0] x_c, y_c;

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst_a), .pll_locked(lk_a), .hsync(hs_a), .vsync(vs_a),
      .de(de_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a));

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(10), .V_FP(1), .V_SYNC(3), .V_BP(2),
      .H_POL(1), .V_POL(1), .COORD_W(11)
   ) dut_b (
      .clk(clk), .rst(rst_b), .pll_locked(lk_b), .hsync(hs_b), .vsync(vs_b),
      .de(de_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b));

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(0), .V_POL(0), .COORD_W(11)
   ) dut_c (
      .clk(clk), .rst(rst_c), .pll_locked(lk_c), .hsync(hs_c), .vsync(vs_c),
      .de(de_c), .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c));

   task automatic test_reset();
      logic [24:0] obs;
      rst_a = 1'b1; lk_a = 1'b1;
      repeat (10) @(negedge clk);
      total_cnt++; if (hs_a !== 1'b0) $display("FAIL reset_hsync: got %b want 0", hs_a); else pass_cnt++;
      total_cnt++; if (vs_a !== 1'b0) $display("FAIL reset_vsync: got %b want 0", vs_a); else pass_cnt++;
      total_cnt++; if (de_a !== 1'b0) $display("FAIL reset_de: got %b want 0", de_a); else pass_cnt++;
      total_cnt++; if (x_a !== 11'd0) $display("FAIL reset_x: got %0d want 0", x_a); else pass_cnt++;
      total_cnt++; if (y_a !== 11'd0) $display("FAIL reset_y: got %0d want 0", y_a); else pass_cnt++;
      total_cnt++; if ({ls_a, fs_a} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {ls_a, fs_a}); else pass_cnt++;
      rst_a = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (i < 3) begin
            total_cnt++;
            if ({fs_a, de_a, x_a} !== 13'd0) $display("FAIL startup_early_%0d: got fs=%b de=%b x=%0d want all 0", i, fs_a, de_a, x_a);
            else pass_cnt++;
         end else begin
            obs = {fs_a, ls_a, de_a, x_a, y_a};
            total_cnt++;
            if (obs !== {3'b111, 11'd0, 11'd0}) $display("FAIL startup_first_pixel: got fs=%b ls=%b de=%b x=%0d y=%0d want 1 1 1 0 0", fs_a, ls_a, de_a, x_a, y_a);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_line_timing();
      int last_ls, ls_n, de_run, hs_run, xy_err;
      logic prev_de, prev_hs;
      last_ls = -1; ls_n = 0; de_run = 0; hs_run = 0; xy_err = 0;
      prev_de = 1'b0; prev_hs = 1'b0;
      for (int c = 0; c < 3 * 1688; c++) begin
         if (ls_a) begin
            if (last_ls >= 0) begin
               total_cnt++;
               if (c - last_ls != 1688) $display("FAIL line_period: got %0d want 1688", c - last_ls); else pass_cnt++;
            end
            last_ls = c; ls_n++;
         end
         if (de_a) de_run++;
         else if (prev_de) begin
            total_cnt++;
            if (de_run != 1280) $display("FAIL de_run: got %0d want 1280", de_run); else pass_cnt++;
            de_run = 0;
         end
         if (hs_a && !prev_hs) begin
            total_cnt++;
            if (int'(x_a) != 1328) $display("FAIL hsync_start_x: got %0d want 1328", x_a); else pass_cnt++;
         end
         if (hs_a) hs_run++;
         else if (prev_hs) begin
            total_cnt++;
            if (hs_run != 112) $display("FAIL hsync_width: got %0d want 112", hs_run); else pass_cnt++;
            hs_run = 0;
         end
         if (int'(x_a) != c % 1688 || int'(y_a) != c / 1688) xy_err++;
         prev_de = de_a; prev_hs = hs_a;
         @(negedge clk);
      end
      total_cnt++; if (ls_n != 3) $display("FAIL line_start_count: got %0d want 3", ls_n); else pass_cnt++;
      total_cnt++; if (xy_err != 0) $display("FAIL line_xy_track: got %0d bad cycles want 0", xy_err); else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20000 && !found; i++) begin
         if (int'(x_a) == 100 && int'(y_a) == 10) found = 1'b1;
         else @(negedge clk);
      end
      total_cnt++;
      if (!found) begin
         $display("FAIL rst_mid_reach: got timeout want x=100 y=10");
      end else begin
         pass_cnt++;
         rst_a = 1'b1;
         @(negedge clk);
         rst_a = 1'b0;
         total_cnt++;
         if ({hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a} !== 27'd0)
            $display("FAIL rst_mid_values: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d want all 0", hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a);
         else pass_cnt++;
         for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (i < 3) begin
               if ({fs_a, x_a} !== 12'd0) $display("FAIL rst_mid_hold_%0d: got fs=%b x=%0d want 0 0", i, fs_a, x_a); else pass_cnt++;
            end else begin
               if ({fs_a, de_a, x_a, y_a} !== {2'b11, 22'd0}) $display("FAIL rst_mid_restart: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", fs_a, de_a, x_a, y_a);
               else pass_cnt++;
            end
         end
         @(negedge clk);
         total_cnt++; if (x_a !== 11'd1) $display("FAIL rst_mid_next_x: got %0d want 1", x_a); else pass_cnt++;
      end
   endtask

   task automatic test_lock_loss();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20000 && !found; i++) begin
         if (int'(x_a) == 700 && int'(y_a) == 5) found = 1'b1;
         else @(negedge clk);
      end
      total_cnt++;
      if (!found) begin
         $display("FAIL lock_reach: got timeout want x=700 y=5");
      end else begin
         pass_cnt++;
         lk_a = 1'b0;
         @(negedge clk);
         total_cnt++; if (x_a !== 11'd701 || de_a !== 1'b1) $display("FAIL lock_drop_1: got x=%0d de=%b want 701 1", x_a, de_a); else pass_cnt++;
         @(negedge clk);
         total_cnt++; if (x_a !== 11'd702) $display("FAIL lock_drop_2: got x=%0d want 702", x_a); else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if ({hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a} !== 27'd0)
            $display("FAIL lock_drop_reset: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d want all 0", hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a);
         else pass_cnt++;
         repeat (2) @(negedge clk);
         total_cnt++; if ({de_a, x_a, y_a} !== 23'd0) $display("FAIL lock_low_hold: got de=%b x=%0d y=%0d want 0 0 0", de_a, x_a, y_a); else pass_cnt++;
         lk_a = 1'b1;
         for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (i < 3) begin
               if ({fs_a, x_a} !== 12'd0) $display("FAIL relock_hold_%0d: got fs=%b x=%0d want 0 0", i, fs_a, x_a); else pass_cnt++;
            end else begin
               if ({fs_a, x_a, y_a} !== {1'b1, 22'd0}) $display("FAIL relock_frame_start: got fs=%b x=%0d y=%0d want 1 0 0", fs_a, x_a, y_a);
               else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_frame_timing();
      int last_fs, fs_n, de0, de1, vs_run;
      logic prev_vs;
      logic [10:0] prev_x, prev_y;
      last_fs = -1; fs_n = 0; de0 = 0; de1 = 0; vs_run = 0;
      prev_vs = 1'b0; prev_x = '0; prev_y = '0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (fs_b !== 1'b1) $display("FAIL frame_first_fs: got %b want 1", fs_b); else pass_cnt++;
      for (int c = 0; c <= 800; c++) begin
         if (fs_b) begin
            if (last_fs >= 0) begin
               total_cnt++;
               if (c - last_fs != 400) $display("FAIL frame_period: got %0d want 400", c - last_fs); else pass_cnt++;
               total_cnt++;
               if (int'(prev_x) != 24 || int'(prev_y) != 15) $display("FAIL frame_wrap: got prev x=%0d y=%0d want 24 15", prev_x, prev_y); else pass_cnt++;
            end
            last_fs = c; fs_n++;
         end
         if (c < 400) de0 += int'(de_b);
         else if (c < 800) de1 += int'(de_b);
         if (vs_b && !prev_vs) begin
            total_cnt++;
            if (int'(x_b) != 0 || int'(y_b) != 11) $display("FAIL vsync_rise: got x=%0d y=%0d want 0 11", x_b, y_b); else pass_cnt++;
         end
         if (vs_b) vs_run++;
         else if (prev_vs) begin
            total_cnt++;
            if (vs_run != 75) $display("FAIL vsync_width: got %0d want 75", vs_run); else pass_cnt++;
            vs_run = 0;
         end
         prev_vs = vs_b; prev_x = x_b; prev_y = y_b;
         @(negedge clk);
      end
      total_cnt++; if (fs_n != 3) $display("FAIL frame_start_count: got %0d want 3", fs_n); else pass_cnt++;
      total_cnt++; if (de0 != 160) $display("FAIL frame_de_count_0: got %0d want 160", de0); else pass_cnt++;
      total_cnt++; if (de1 != 160) $display("FAIL frame_de_count_1: got %0d want 160", de1); else pass_cnt++;
   endtask

   task automatic test_polarity();
      int last_ls, last_fs, fs_n, hs_err, vs_err, xy_err;
      logic exp_hs, exp_vs;
      last_ls = -1; last_fs = -1; fs_n = 0; hs_err = 0; vs_err = 0; xy_err = 0;
      total_cnt++;
      if ({hs_c, vs_c, de_c} !== 3'b110) $display("FAIL pol_reset: got hs=%b vs=%b de=%b want 1 1 0", hs_c, vs_c, de_c); else pass_cnt++;
      rst_c = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (fs_c !== 1'b1) $display("FAIL pol_first_fs: got %b want 1", fs_c); else pass_cnt++;
      for (int c = 0; c <= 96; c++) begin
         if (ls_c) begin
            if (last_ls >= 0 && c <= 24) begin
               total_cnt++;
               if (c - last_ls != 8) $display("FAIL pol_line_period: got %0d want 8", c - last_ls); else pass_cnt++;
            end
            last_ls = c;
         end
         if (fs_c) begin
            if (last_fs >= 0) begin
               total_cnt++;
               if (c - last_fs != 48) $display("FAIL pol_frame_period: got %0d want 48", c - last_fs); else pass_cnt++;
            end
            last_fs = c; fs_n++;
         end
         exp_hs = !(int'(x_c) == 5 || int'(x_c) == 6);
         exp_vs = !(int'(y_c) == 4);
         if (hs_c !== exp_hs) hs_err++;
         if (vs_c !== exp_vs) vs_err++;
         if (int'(x_c) != c % 8 || int'(y_c) != (c / 8) % 6) xy_err++;
         @(negedge clk);
      end
      total_cnt++; if (fs_n != 3) $display("FAIL pol_fs_count: got %0d want 3", fs_n); else pass_cnt++;
      total_cnt++; if (hs_err != 0) $display("FAIL pol_hsync_low_x5_6: got %0d bad cycles want 0", hs_err); else pass_cnt++;
      total_cnt++; if (vs_err != 0) $display("FAIL pol_vsync_low_y4: got %0d bad cycles want 0", vs_err); else pass_cnt++;
      total_cnt++; if (xy_err != 0) $display("FAIL pol_xy_track: got %0d bad cycles want 0", xy_err); else pass_cnt++;
   endtask

   initial begin
      rst_a = 1'b1; lk_a = 1'b1;
      rst_b = 1'b1; lk_b = 1'b1;
      rst_c = 1'b1; lk_c = 1'b1;
      @(negedge clk);
      test_reset();
      test_line_timing();
      test_rst_mid();
      test_lock_loss();
      test_frame_timing();
      test_polarity();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
